johnson_seq_ctrl: RTL and testbench
===================================

// Module: johnson_seq_ctrl
// PURPOSE
// Run controller for a WIDTH-bit Johnson counter datapath. The block owns the counter register and
// sequences it for a requested number of full rotations, with start/hold/stop control and seed loading.
// It reports phase index, busy and done, and flags illegal (non-Johnson) codes and forces them clean.
// It sits between a host or sequencer FSM and any logic that consumes the phase.
// PARAMETERS
// WIDTH  4  Johnson register width; one rotation is 2*WIDTH steps
// CYC_W  8  width of the rotation-count request
// PH_W   $clog2(2*WIDTH)  phase index width (localparam)
// PORTS
// clk         in   1      clock, rising edge
// rst         in   1      synchronous active-high reset
// start       in   1      start request, sampled in IDLE only
// hold        in   1      stall stepping while RUN
// stop        in   1      abort run, back to IDLE
// num_cycles  in   CYC_W  rotations to run, latched on accepted start
// load_en     in   1      load seed, IDLE only
// load_val    in   WIDTH  seed value
// count       out  WIDTH  Johnson register
// phase       out  PH_W   phase index 0..2*WIDTH-1 of count
// busy        out  1      high while state != IDLE
// done        out  1      one-cycle pulse on normal completion
// err_illegal out  1      one-cycle pulse on illegal seed
// BEHAVIOUR
// - Reset: state=IDLE, count=0, busy=0, done=0, err_illegal=0, internal step/cycle counters=0.
// - Step rule: count <= {~count[0], count[WIDTH-1:1]}. For WIDTH=4 from 0000 the sequence is
//   1000,1100,1110,1111,0111,0011,0001,0000.
// - Legal code: at most one i in 0..WIDTH-2 with count[i]!=count[i+1].
// - phase (combinational from count): if count==0 or count[WIDTH-1], phase=popcount;
//   otherwise phase=2*WIDTH-popcount.
// - FSM IDLE:
//   - load_en with a legal load_val: count<=load_val.
//   - load_en with an illegal load_val: count<=0 and err_illegal=1 for one cycle.
//   - load_en and start in the same cycle: load wins, start is ignored.
//   - start with num_cycles!=0: go to RUN, busy=1 from the next cycle, latch num_cycles, clear step counter.
//   - start with num_cycles==0: stay IDLE, done=1 for one cycle, count unchanged.
// - FSM RUN:
//   - On each edge with hold=0 and stop=0, count steps and the step counter increments.
//   - When the step counter wraps from 2*WIDTH-1, the remaining-rotation count decrements.
//   - The edge that takes the final step (num_cycles*2*WIDTH total) sets state=IDLE, busy=0 and done=1
//     for one cycle. count then equals its value at start.
//   - hold=1: no step, counters frozen, busy stays 1.
//   - stop=1 (priority over hold): state=IDLE, busy=0, done stays 0, count keeps its current value.
//   - start and load_en are ignored while RUN.
// - Latency: start accepted at edge T0, first step at T1, done visible after edge T(num_cycles*2*WIDTH)
//   when no hold cycles occur.
// - rst mid-run: full reset values on the next edge and no done pulse. rst has priority over all inputs.
// - No output is X after reset. done and err_illegal never stay high for more than one cycle.
// TESTING
// - rst=1 for 2 cycles -> count=0000, phase=0, busy=0, done=0, err_illegal=0.
// - From 0000, start with num_cycles=2 -> 16 steps through the sequence twice, phase 1..7,0 each rotation,
//   done pulse exactly 16 cycles after the start edge, count=0000, busy=0.
// - During num_cycles=1, hold=1 for 3 cycles after step 2 (count=1100) -> count held at 1100,
//   done delayed by 3 cycles.
// - stop asserted at count=1111 -> IDLE next cycle, count=1111, done stays 0. A new start with num_cycles=1
//   from there -> 8 steps, ends at 1111 with a done pulse.
// - load_en with load_val=0100 -> err_illegal pulse, count=0000.
//   load_en with load_val=0011 -> count=0011, phase=6, no err.
// - start with num_cycles=0 -> done pulse and no stepping.
//   rst asserted mid-run -> reset values, no done pulse.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson counter run controller: steps the owned register for N full rotations with hold/stop and seed load.
// Latency: start accepted at edge T0, first step at T1, done pulses after edge T(N*2*WIDTH); hold stalls, stop aborts.
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8,
    localparam int PH_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             stop,
    input  logic [CYC_W-1:0] num_cycles,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [PH_W-1:0]  phase,
    output logic             busy,
    output logic             done,
    output logic             err_illegal
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PH_W-1:0] LAST_STEP = PH_W'(2*WIDTH-1);

    state_t           state, state_d;
    logic [WIDTH-1:0] count_d;
    logic [PH_W-1:0]  step_cnt, step_d;
    logic [CYC_W-1:0] rem_cnt, rem_d;
    logic             done_d, err_d;

    function automatic int popcnt(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) n++;
        return n;
    endfunction

    // A Johnson code has at most one boundary between its ones-run and zeros-run.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH-1; i++)
            if (v[i] != v[i+1]) n++;
        return (n <= 1);
    endfunction

    always_comb begin
        int pc;
        pc = popcnt(count);
        if (count == '0 || count[WIDTH-1])
            phase = PH_W'(pc);
        else
            phase = PH_W'(2*WIDTH - pc);
    end

    assign busy = (state == RUN);

    always_comb begin
        state_d = state;
        count_d = count;
        step_d  = step_cnt;
        rem_d   = rem_cnt;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    if (is_legal(load_val)) begin
                        count_d = load_val;
                    end else begin
                        count_d = '0;
                        err_d   = 1'b1;
                    end
                end else if (start) begin
                    if (num_cycles != '0) begin
                        state_d = RUN;
                        rem_d   = num_cycles;
                        step_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    count_d = {~count[0], count[WIDTH-1:1]};
                    if (step_cnt == LAST_STEP) begin
                        step_d = '0;
                        if (rem_cnt == CYC_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                        rem_d = rem_cnt - CYC_W'(1);
                    end else begin
                        step_d = step_cnt + PH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            step_cnt    <= '0;
            rem_cnt     <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            step_cnt    <= step_d;
            rem_cnt     <= rem_d;
            done        <= done_d;
            err_illegal <= err_d;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Bench for johnson_seq_ctrl: directed scenarios then random traffic against a phase-position reference model.
module tb_johnson_seq_ctrl;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int PW   = $clog2(2*W);
    localparam int ROT  = 2*W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, hold = 1'b0, stop = 1'b0, load_en = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  count;
    logic [PW-1:0] phase;
    logic          busy, done, err_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the register is tracked as a position on the ring, plus steps left.
    int m_pos = 0;
    int m_left = 0;
    bit m_run = 0, m_done = 0, m_err = 0;

    johnson_seq_ctrl #(.WIDTH(W), .CYC_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .stop(stop),
        .num_cycles(num_cycles), .load_en(load_en), .load_val(load_val),
        .count(count), .phase(phase), .busy(busy), .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] code_of(input int pos);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++)
            if (pos <= W) c[i] = (i >= W - pos);
            else          c[i] = (i < ROT - pos);
        return c;
    endfunction

    function automatic int pos_of(input logic [W-1:0] c);
        for (int p = 0; p < ROT; p++)
            if (code_of(p) == c) return p;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int p;
        if (rst) begin
            m_pos = 0; m_left = 0; m_run = 0; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (!m_run) begin
            if (load_en) begin
                p = pos_of(load_val);
                if (p < 0) begin m_pos = 0; m_err = 1; end
                else m_pos = p;
            end else if (start) begin
                if (num_cycles == 0) m_done = 1;
                else begin m_run = 1; m_left = int'(num_cycles) * ROT; end
            end
        end else if (stop) begin
            m_run = 0;
        end else if (!hold) begin
            m_pos = (m_pos + 1) % ROT;
            m_left--;
            if (m_left == 0) begin m_run = 0; m_done = 1; end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(code_of(m_pos)));
        chk("phase", 32'(phase), 32'(m_pos));
        chk("busy",  32'(busy),  32'(m_run));
        chk("done",  32'(done),  32'(m_done));
        chk("err",   32'(err_illegal), 32'(m_err));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // reset for two cycles
        cycles(2);
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);

        // two rotations from 0000; done lands on the 16th edge after start
        start = 1'b1; num_cycles = 8'd2;
        cycle();
        start = 1'b0;
        cycles(15);
        chk("pre_done", 32'(done), 32'h0);
        cycle();
        chk("done16", 32'(done), 32'h1);
        cycles(2);

        // one rotation with a 3-cycle hold at 1100
        start = 1'b1; num_cycles = 8'd1;
        cycle();
        start = 1'b0;
        cycles(2);
        chk("hold_at", 32'(count), 32'hC);
        hold = 1'b1;
        cycles(3);
        chk("held", 32'(count), 32'hC);
        hold = 1'b0;
        cycles(7);

        // stop at 1111, then a fresh rotation from there
        start = 1'b1; num_cycles = 8'd1;
        cycle();
        start = 1'b0;
        cycles(4);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_count", 32'(count), 32'hF);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycles(9);
        chk("rerun_end", 32'(count), 32'hF);

        // seed loading: illegal then legal, with a colliding start
        load_en = 1'b1; load_val = 4'b0100;
        cycle();
        load_val = 4'b0011; start = 1'b1;
        cycle();
        load_en = 1'b0; start = 1'b0;
        chk("load_phase", 32'(phase), 32'h6);
        cycle();

        // zero-rotation start, then reset mid-run
        start = 1'b1; num_cycles = 8'd0;
        cycle();
        num_cycles = 8'd3;
        cycle();
        start = 1'b0;
        cycles(5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycles(3);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            hold       = ($urandom_range(0, 4) == 0);
            start      = ($urandom_range(0, 3) == 0);
            load_en    = ($urandom_range(0, 7) == 0);
            load_val   = ($urandom_range(0, 1) == 0) ? code_of($urandom_range(0, ROT-1))
                                                     : W'($urandom);
            num_cycles = CW'($urandom_range(0, 3));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
